// File: rtl/exe_alu_core.sv
// Execute-stage arithmetic core: operand bypass selection, 32-bit integer ALU
// and the architectural HI/LO register pair.
module exe_alu_core (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        FLUSH,
   input  logic [4:0]  RegA,
   input  logic [4:0]  RegB,
   input  logic [31:0] OpA,
   input  logic [31:0] OpB,
   input  logic [4:0]  RegStore,
   input  logic [31:0] StoreData,
   input  logic [4:0]  Fwd1Reg,
   input  logic [31:0] Fwd1Data,
   input  logic        Fwd1Valid,
   input  logic [4:0]  Fwd2Reg,
   input  logic [31:0] Fwd2Data,
   input  logic        Fwd2Valid,
   input  logic [5:0]  ALUControl,
   input  logic [4:0]  ShiftAmount,
   output logic [31:0] A_fwd,
   output logic [31:0] B_fwd,
   output logic [31:0] StoreData_fwd,
   output logic [31:0] Result,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   localparam logic [5:0] OP_ADD  = 6'h00, OP_ADDU  = 6'h01, OP_SUB  = 6'h02, OP_SUBU = 6'h03;
   localparam logic [5:0] OP_AND  = 6'h04, OP_OR    = 6'h05, OP_XOR  = 6'h06, OP_NOR  = 6'h07;
   localparam logic [5:0] OP_SLT  = 6'h08, OP_SLTU  = 6'h09, OP_SLL  = 6'h0A, OP_SRL  = 6'h0B;
   localparam logic [5:0] OP_SRA  = 6'h0C, OP_SLLV  = 6'h0D, OP_SRLV = 6'h0E, OP_SRAV = 6'h0F;
   localparam logic [5:0] OP_LUI  = 6'h10, OP_MULT  = 6'h11, OP_MULTU = 6'h12, OP_DIV = 6'h13;
   localparam logic [5:0] OP_DIVU = 6'h14, OP_MFHI  = 6'h15, OP_MFLO = 6'h16, OP_MTHI = 6'h17;
   localparam logic [5:0] OP_MTLO = 6'h18, OP_PASSA = 6'h19, OP_PASSB = 6'h1A;

   // Register $zero is never forwarded; the EXE/MEM bypass beats MEM/WB.
   function automatic logic [31:0] bypass_sel(
      input logic [4:0]  r,
      input logic [31:0] v,
      input logic [4:0]  f1_reg,
      input logic [31:0] f1_data,
      input logic        f1_valid,
      input logic [4:0]  f2_reg,
      input logic [31:0] f2_data,
      input logic        f2_valid
   );
      logic [31:0] sel;
      if (r == 5'd0) sel = v;
      else if (f1_valid && (f1_reg == r)) sel = f1_data;
      else if (f2_valid && (f2_reg == r)) sel = f2_data;
      else sel = v;
      return sel;
   endfunction

   logic [31:0] a_s, b_s, store_s, result_s;
   logic [31:0] hi_r, lo_r, hi_next_s, lo_next_s;
   logic        hilo_we_s;
   logic        mul_signed_s, div_signed_s, div_zero_s;
   logic [63:0] mul_a_s, mul_b_s, mul_s;
   logic [31:0] a_mag_s, b_mag_s, divisor_s, q_mag_s, r_mag_s, quo_s, rem_s;

   // operand bypass selection for A, B and store data
   always_comb begin
      a_s     = bypass_sel(RegA, OpA, Fwd1Reg, Fwd1Data, Fwd1Valid, Fwd2Reg, Fwd2Data, Fwd2Valid);
      b_s     = bypass_sel(RegB, OpB, Fwd1Reg, Fwd1Data, Fwd1Valid, Fwd2Reg, Fwd2Data, Fwd2Valid);
      store_s = bypass_sel(RegStore, StoreData, Fwd1Reg, Fwd1Data, Fwd1Valid, Fwd2Reg, Fwd2Data, Fwd2Valid);
   end

   // 64-bit product, operands sign- or zero-extended according to MULT/MULTU
   always_comb begin
      mul_signed_s = (ALUControl == OP_MULT);
      mul_a_s      = {{32{mul_signed_s & a_s[31]}}, a_s};
      mul_b_s      = {{32{mul_signed_s & b_s[31]}}, b_s};
      mul_s        = mul_a_s * mul_b_s;
   end

   // Sign-magnitude division keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
   always_comb begin
      div_signed_s = (ALUControl == OP_DIV);
      div_zero_s   = (b_s == 32'd0);
      a_mag_s      = (div_signed_s && a_s[31]) ? (32'd0 - a_s) : a_s;
      b_mag_s      = (div_signed_s && b_s[31]) ? (32'd0 - b_s) : b_s;
      divisor_s    = div_zero_s ? 32'd1 : b_mag_s;
      q_mag_s      = a_mag_s / divisor_s;
      r_mag_s      = a_mag_s % divisor_s;
      quo_s        = (div_signed_s && (a_s[31] ^ b_s[31])) ? (32'd0 - q_mag_s) : q_mag_s;
      rem_s        = (div_signed_s && a_s[31]) ? (32'd0 - r_mag_s) : r_mag_s;
   end

   // ALU result and HI/LO next-state selection
   always_comb begin
      result_s  = 32'd0;
      hi_next_s = hi_r;
      lo_next_s = lo_r;
      hilo_we_s = 1'b0;
      case (ALUControl)
         OP_ADD, OP_ADDU: result_s = a_s + b_s;
         OP_SUB, OP_SUBU: result_s = a_s - b_s;
         OP_AND:   result_s = a_s & b_s;
         OP_OR:    result_s = a_s | b_s;
         OP_XOR:   result_s = a_s ^ b_s;
         OP_NOR:   result_s = ~(a_s | b_s);
         OP_SLT:   result_s = ($signed(a_s) < $signed(b_s)) ? 32'd1 : 32'd0;
         OP_SLTU:  result_s = (a_s < b_s) ? 32'd1 : 32'd0;
         OP_SLL:   result_s = b_s << ShiftAmount;
         OP_SRL:   result_s = b_s >> ShiftAmount;
         OP_SRA:   result_s = $signed(b_s) >>> ShiftAmount;
         OP_SLLV:  result_s = b_s << a_s[4:0];
         OP_SRLV:  result_s = b_s >> a_s[4:0];
         OP_SRAV:  result_s = $signed(b_s) >>> a_s[4:0];
         OP_LUI:   result_s = {b_s[15:0], 16'h0000};
         OP_MULT, OP_MULTU: begin
            hilo_we_s = 1'b1;
            hi_next_s = mul_s[63:32];
            lo_next_s = mul_s[31:0];
         end
         OP_DIV, OP_DIVU: begin
            if (div_zero_s) begin
               hilo_we_s = 1'b0;
            end else begin
               hilo_we_s = 1'b1;
               hi_next_s = rem_s;
               lo_next_s = quo_s;
            end
         end
         OP_MFHI:  result_s = hi_r;
         OP_MFLO:  result_s = lo_r;
         OP_MTHI: begin
            hilo_we_s = 1'b1;
            hi_next_s = a_s;
         end
         OP_MTLO: begin
            hilo_we_s = 1'b1;
            lo_next_s = a_s;
         end
         OP_PASSA: result_s = a_s;
         OP_PASSB: result_s = b_s;
         default:  result_s = 32'd0;
      endcase
   end

   // HI/LO register pair; FLUSH cancels the write of the current cycle
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         hi_r <= 32'd0;
         lo_r <= 32'd0;
      end else if (hilo_we_s && !FLUSH) begin
         hi_r <= hi_next_s;
         lo_r <= lo_next_s;
      end
   end

   assign A_fwd         = a_s;
   assign B_fwd         = b_s;
   assign StoreData_fwd = store_s;
   assign Result        = result_s;
   assign HI            = hi_r;
   assign LO            = lo_r;
endmodule

// File: tb/tb_exe_alu_core.sv
// Self-checking bench for exe_alu_core: vector table, hand-written HI/LO
// sequences and randomized stimulus against a behavioural model.
module tb_exe_alu_core;
   logic        CLK, RESET, FLUSH;
   logic [4:0]  RegA, RegB, RegStore, Fwd1Reg, Fwd2Reg, ShiftAmount;
   logic [31:0] OpA, OpB, StoreData, Fwd1Data, Fwd2Data;
   logic        Fwd1Valid, Fwd2Valid;
   logic [5:0]  ALUControl;
   logic [31:0] A_fwd, B_fwd, StoreData_fwd, Result, HI, LO;

   int total = 0;
   int bad   = 0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

   exe_alu_core dut (
      .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
      .RegA(RegA), .RegB(RegB), .OpA(OpA), .OpB(OpB),
      .RegStore(RegStore), .StoreData(StoreData),
      .Fwd1Reg(Fwd1Reg), .Fwd1Data(Fwd1Data), .Fwd1Valid(Fwd1Valid),
      .Fwd2Reg(Fwd2Reg), .Fwd2Data(Fwd2Data), .Fwd2Valid(Fwd2Valid),
      .ALUControl(ALUControl), .ShiftAmount(ShiftAmount),
      .A_fwd(A_fwd), .B_fwd(B_fwd), .StoreData_fwd(StoreData_fwd),
      .Result(Result), .HI(HI), .LO(LO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] v);
      if (r == 5'd0) return v;
      if (Fwd1Valid && Fwd1Reg == r) return Fwd1Data;
      if (Fwd2Valid && Fwd2Reg == r) return Fwd2Data;
      return v;
   endfunction

   // reference ALU: plain integer arithmetic on the resolved operands
   task automatic m_eval(output logic [31:0] res, output logic [31:0] hn, output logic [31:0] ln);
      logic [31:0] a, b;
      longint sa, sb, q, rm;
      logic [63:0] t, t2;
      int si;
      a = m_fwd(RegA, OpA);
      b = m_fwd(RegB, OpB);
      sa = int'(a);
      sb = int'(b);
      si = int'(b);
      res = 32'd0; hn = m_hi; ln = m_lo;
      case (int'(ALUControl))
         0, 1: res = a + b;
         2, 3: res = a - b;
         4: res = a & b;
         5: res = a | b;
         6: res = a ^ b;
         7: res = ~(a | b);
         8: res = (sa < sb) ? 32'd1 : 32'd0;
         9: res = (a < b) ? 32'd1 : 32'd0;
         10: res = b << ShiftAmount;
         11: res = b >> ShiftAmount;
         12: res = si >>> ShiftAmount;
         13: res = b << (a % 32);
         14: res = b >> (a % 32);
         15: res = si >>> (a % 32);
         16: res = b * 32'd65536;
         17: begin t = sa * sb; hn = t[63:32]; ln = t[31:0]; end
         18: begin t = 64'(a) * 64'(b); hn = t[63:32]; ln = t[31:0]; end
         19: if (b != 32'd0) begin
            q = sa / sb; rm = sa % sb; t = q; t2 = rm;
            ln = t[31:0]; hn = t2[31:0];
         end
         20: if (b != 32'd0) begin ln = a / b; hn = a % b; end
         21: res = m_hi;
         22: res = m_lo;
         23: hn = a;
         24: ln = a;
         25: res = a;
         26: res = b;
         default: res = 32'd0;
      endcase
   endtask

   // one full cycle starting at posedge+1: check combinational outputs, clock, check HI/LO
   task automatic run_cycle(input string tag);
      logic [31:0] res, hn, ln;
      #2;
      m_eval(res, hn, ln);
      chk({tag, "_afwd"}, A_fwd, m_fwd(RegA, OpA));
      chk({tag, "_bfwd"}, B_fwd, m_fwd(RegB, OpB));
      chk({tag, "_sfwd"}, StoreData_fwd, m_fwd(RegStore, StoreData));
      chk({tag, "_result"}, Result, res);
      @(posedge CLK);
      if (!FLUSH) begin m_hi = hn; m_lo = ln; end
      #1;
      chk({tag, "_hi"}, HI, m_hi);
      chk({tag, "_lo"}, LO, m_lo);
   endtask

   task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic fl);
      RegA = 5'd0; RegB = 5'd0; RegStore = 5'd0;
      Fwd1Valid = 1'b0; Fwd2Valid = 1'b0;
      ALUControl = op; OpA = a; OpB = b; ShiftAmount = sh; FLUSH = fl;
      run_cycle(tag);
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 40));
         4: return 32'd0 - 32'($urandom_range(1, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      vecs[0]  = '{6'h00, 32'hFFFF_FFFF, 32'h1,          5'd0,  32'h0};
      vecs[1]  = '{6'h02, 32'd3,         32'd5,          5'd0,  32'hFFFF_FFFE};
      vecs[2]  = '{6'h08, 32'hFFFF_FFFF, 32'd1,          5'd0,  32'h1};
      vecs[3]  = '{6'h09, 32'hFFFF_FFFF, 32'd1,          5'd0,  32'h0};
      vecs[4]  = '{6'h07, 32'h0,         32'h0,          5'd0,  32'hFFFF_FFFF};
      vecs[5]  = '{6'h0C, 32'h0,         32'h8000_0000,  5'd4,  32'hF800_0000};
      vecs[6]  = '{6'h0E, 32'd36,        32'h100,        5'd0,  32'h10};
      vecs[7]  = '{6'h10, 32'h0,         32'h1234,       5'd0,  32'h1234_0000};
      vecs[8]  = '{6'h04, 32'hF0F0_F0F0, 32'hFF00_FF00,  5'd0,  32'hF000_F000};
      vecs[9]  = '{6'h06, 32'hFF,        32'h0F,         5'd0,  32'hF0};
      vecs[10] = '{6'h0A, 32'h0,         32'h1,          5'd31, 32'h8000_0000};
      vecs[11] = '{6'h0F, 32'd33,        32'h8000_0000,  5'd0,  32'hC000_0000};
      vecs[12] = '{6'h1A, 32'h5,         32'hDEAD,       5'd0,  32'hDEAD};
      vecs[13] = '{6'h3F, 32'h5,         32'h7,          5'd0,  32'h0};
      vecs[14] = '{6'h0B, 32'h0,         32'h8000_0000,  5'd31, 32'h1};

      RESET = 1'b0; FLUSH = 1'b0;
      RegA = 5'd0; RegB = 5'd0; RegStore = 5'd0; OpA = 32'd0; OpB = 32'd0; StoreData = 32'd0;
      Fwd1Reg = 5'd0; Fwd1Data = 32'd0; Fwd1Valid = 1'b0;
      Fwd2Reg = 5'd0; Fwd2Data = 32'd0; Fwd2Valid = 1'b0;
      ALUControl = 6'h00; ShiftAmount = 5'd0;
      #3;
      chk("reset_hi", HI, 32'd0);
      chk("reset_lo", LO, 32'd0);
      repeat (2) @(posedge CLK);
      @(negedge CLK) RESET = 1'b1;
      @(posedge CLK); #1;

      // bypass priority
      @(negedge CLK);
      RegA = 5'd5; OpA = 32'd1; RegStore = 5'd5; StoreData = 32'd2;
      Fwd1Reg = 5'd5; Fwd1Data = 32'hAA; Fwd1Valid = 1'b1;
      Fwd2Reg = 5'd5; Fwd2Data = 32'hBB; Fwd2Valid = 1'b1;
      #1 chk("byp_both", A_fwd, 32'hAA);
      chk("byp_store", StoreData_fwd, 32'hAA);
      @(negedge CLK) Fwd1Valid = 1'b0;
      #1 chk("byp_fwd2", A_fwd, 32'hBB);
      @(negedge CLK) Fwd2Valid = 1'b0;
      #1 chk("byp_none", A_fwd, 32'h1);
      @(negedge CLK);
      RegA = 5'd0; Fwd1Reg = 5'd0; Fwd2Reg = 5'd0; Fwd1Valid = 1'b1; Fwd2Valid = 1'b1;
      #1 chk("byp_zero", A_fwd, 32'h1);
      @(negedge CLK) Fwd1Valid = 1'b0; Fwd2Valid = 1'b0;

      // combinational vector table
      foreach (vecs[i]) begin
         @(negedge CLK);
         ALUControl = vecs[i].op; OpA = vecs[i].a; OpB = vecs[i].b; ShiftAmount = vecs[i].sh;
         #1 chk($sformatf("vec%0d_op%0h", i, vecs[i].op), Result, vecs[i].exp);
      end
      @(posedge CLK); #1;

      // HI/LO sequences
      do_op("mult", 6'h11, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b0);
      chk("mult_hi_c", HI, 32'hFFFF_FFFF);
      chk("mult_lo_c", LO, 32'hFFFF_FFFA);
      do_op("mflo", 6'h16, 32'd0, 32'd0, 5'd0, 1'b0);
      chk("mflo_c", Result, 32'hFFFF_FFFA);
      do_op("multu", 6'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
      chk("multu_hi_c", HI, 32'hFFFF_FFFE);
      chk("multu_lo_c", LO, 32'h1);
      do_op("div", 6'h13, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0);
      chk("div_lo_c", LO, 32'hFFFF_FFFD);
      chk("div_hi_c", HI, 32'hFFFF_FFFF);
      do_op("divu0", 6'h14, 32'd5, 32'd0, 5'd0, 1'b0);
      chk("divu0_lo_c", LO, 32'hFFFF_FFFD);
      chk("divu0_hi_c", HI, 32'hFFFF_FFFF);
      do_op("divflush", 6'h13, 32'd100, 32'd7, 5'd0, 1'b1);
      chk("divflush_lo_c", LO, 32'hFFFF_FFFD);
      chk("divflush_hi_c", HI, 32'hFFFF_FFFF);
      do_op("divovf", 6'h13, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);
      chk("divovf_lo_c", LO, 32'h8000_0000);
      chk("divovf_hi_c", HI, 32'h0);

      // randomized stimulus against the model
      for (int n = 0; n < 400; n++) begin
         RegA = 5'($urandom_range(0, 3)); RegB = 5'($urandom_range(0, 3));
         RegStore = 5'($urandom_range(0, 3));
         OpA = rand_word(); OpB = rand_word(); StoreData = $urandom;
         Fwd1Reg = 5'($urandom_range(0, 3)); Fwd1Data = rand_word(); Fwd1Valid = 1'($urandom_range(0, 1));
         Fwd2Reg = 5'($urandom_range(0, 3)); Fwd2Data = rand_word(); Fwd2Valid = 1'($urandom_range(0, 1));
         ALUControl = 6'($urandom_range(0, 31)); ShiftAmount = 5'($urandom);
         FLUSH = ($urandom_range(0, 7) == 0);
         run_cycle($sformatf("rnd%0d", n));
      end

      // asynchronous reset between edges
      do_op("mthi", 6'h17, 32'h55, 32'd0, 5'd0, 1'b0);
      chk("mthi_c", HI, 32'h55);
      #2 RESET = 1'b0;
      #1 chk("rst_async_hi", HI, 32'd0);
      chk("rst_async_lo", LO, 32'd0);
      @(posedge CLK); #1;
      chk("rst_hold_hi", HI, 32'd0);
      ALUControl = 6'h19; OpA = 32'h99;
      #1 chk("rst_comb", Result, 32'h99);
      @(negedge CLK) RESET = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;
      @(posedge CLK); #1;
      chk("rst_release_hi", HI, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
